// File: rtl/uart_hram_bridge.sv
// Byte-protocol command bridge: decodes UART command bytes into hyper_xface
// read/write requests and serialises acknowledges and read data back to the UART.
module uart_hram_bridge #(
   parameter int unsigned BUS_TIMEOUT = 1024,
   parameter int unsigned RX_TIMEOUT  = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_strb,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_strb,
   output logic [7:0]  tx_data,
   output logic        rd_req,
   output logic        wr_req,
   output logic [31:0] addr,
   output logic [31:0] wr_d,
   output logic [3:0]  wr_byte_en,
   output logic [5:0]  rd_num_dwords,
   input  logic [31:0] rd_d,
   input  logic        rd_rdy,
   input  logic        busy,
   output logic        err
);

   localparam int unsigned BW = $clog2(BUS_TIMEOUT + 1);
   localparam int unsigned RW = $clog2(RX_TIMEOUT + 1);
   localparam logic [BW-1:0] BUS_LAST = BW'(BUS_TIMEOUT - 1);
   localparam logic [RW-1:0] RX_LAST  = RW'(RX_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PAYLOAD   = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_REPLY     = 3'd4;

   logic [2:0]    state;
   logic          is_write;
   logic [1:0]    byte_cnt;
   logic [31:0]   asm_reg;
   logic [RW-1:0] rx_tmr;
   logic [BW-1:0] bus_tmr;
   logic [31:0]   reply_buf;
   logic [1:0]    reply_left;
   logic          addr_load;
   logic          addr_inc;
   logic [31:0]   payload_word;
   logic          bus_expired;

   assign wr_byte_en    = 4'hF;
   assign rd_num_dwords = 6'd1;
   assign payload_word  = {asm_reg[23:0], rx_data};
   assign bus_expired   = (bus_tmr >= BUS_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         is_write   <= 1'b0;
         byte_cnt   <= 2'd0;
         asm_reg    <= 32'h0;
         rx_tmr     <= '0;
         bus_tmr    <= '0;
         reply_buf  <= 32'h0;
         reply_left <= 2'd0;
         addr_load  <= 1'b0;
         addr_inc   <= 1'b0;
         tx_strb    <= 1'b0;
         tx_data    <= 8'h00;
         rd_req     <= 1'b0;
         wr_req     <= 1'b0;
         addr       <= 32'h0;
         wr_d       <= 32'h0;
         err        <= 1'b0;
      end else begin
         tx_strb <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_strb) begin
                  addr_load <= 1'b0;
                  addr_inc  <= 1'b0;
                  rx_tmr    <= '0;
                  bus_tmr   <= '0;
                  byte_cnt  <= 2'd0;
                  is_write  <= (rx_data == 8'h02);
                  case (rx_data)
                     8'h00: begin
                        err        <= 1'b0;
                        reply_buf  <= {8'h55, 24'h0};
                        reply_left <= 2'd0;
                        state      <= S_REPLY;
                     end
                     8'h01, 8'h02: state <= S_PAYLOAD;
                     8'h03: begin
                        rd_req <= 1'b1;
                        state  <= S_ISSUE;
                     end
                     default: begin
                        err        <= 1'b1;
                        reply_buf  <= {8'hEE, 24'h0};
                        reply_left <= 2'd0;
                        state      <= S_REPLY;
                     end
                  endcase
               end
            end
            S_PAYLOAD: begin
               if (rx_strb) begin
                  asm_reg  <= payload_word;
                  rx_tmr   <= '0;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (is_write) begin
                        wr_d   <= payload_word;
                        wr_req <= 1'b1;
                        state  <= S_ISSUE;
                     end else begin
                        // addr itself is loaded from asm_reg when the ack goes out
                        addr_load  <= 1'b1;
                        reply_buf  <= {8'hAA, 24'h0};
                        reply_left <= 2'd0;
                        state      <= S_REPLY;
                     end
                  end
               end else if (rx_tmr >= RX_LAST) begin
                  state <= S_IDLE;
               end else begin
                  rx_tmr <= rx_tmr + 1'b1;
               end
            end
            S_ISSUE: begin
               if (busy) begin
                  rd_req  <= 1'b0;
                  wr_req  <= 1'b0;
                  bus_tmr <= bus_tmr + 1'b1;
                  state   <= S_WAIT_DONE;
               end else if (bus_expired) begin
                  rd_req     <= 1'b0;
                  wr_req     <= 1'b0;
                  err        <= 1'b1;
                  reply_buf  <= {8'hEE, 24'h0};
                  reply_left <= 2'd0;
                  state      <= S_REPLY;
               end else begin
                  bus_tmr <= bus_tmr + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               // completion is checked before expiry so a late rd_rdy still succeeds
               if (!is_write && rd_rdy) begin
                  reply_buf  <= rd_d;
                  reply_left <= 2'd3;
                  addr_inc   <= 1'b1;
                  state      <= S_REPLY;
               end else if (is_write && !busy) begin
                  reply_buf  <= {8'hAA, 24'h0};
                  reply_left <= 2'd0;
                  addr_inc   <= 1'b1;
                  state      <= S_REPLY;
               end else if (bus_expired) begin
                  err        <= 1'b1;
                  reply_buf  <= {8'hEE, 24'h0};
                  reply_left <= 2'd0;
                  state      <= S_REPLY;
               end else begin
                  bus_tmr <= bus_tmr + 1'b1;
               end
            end
            S_REPLY: begin
               if (tx_ready && !tx_strb) begin
                  tx_strb    <= 1'b1;
                  tx_data    <= reply_buf[31:24];
                  reply_buf  <= {reply_buf[23:0], 8'h00};
                  reply_left <= reply_left - 2'd1;
                  if (reply_left == 2'd0) begin
                     state <= S_IDLE;
                     if (addr_load) begin
                        addr <= asm_reg;
                     end else if (addr_inc) begin
                        addr <= addr + 32'd1;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_hram_bridge.md
# uart_hram_bridge

Byte-protocol command bridge between the UART receiver/transmitter pair and the HyperRAM controller `hyper_xface`. It takes received bytes, decodes ping, set-address, write-dword and read-dword commands, and drives the controller's request handshake. It then serialises the acknowledges and read data back through the UART transmitter. It sits on the controller side of the design and replaces the ad-hoc per-byte case decode in the top level.

## Interface
Parameters:
- `BUS_TIMEOUT`, 1024: max cycles to wait for controller accept/completion before abort.
- `RX_TIMEOUT`, 65535: max idle cycles between payload bytes before a partial command is discarded.

Ports:
- `clk`  in  1  single clock; `rx_*`/`tx_*` are already synchronous to it.
- `reset`  in  1  synchronous, active-high.
- `rx_strb`  in  1  one-cycle pulse: `rx_data` valid.
- `rx_data`  in  8  received byte.
- `tx_ready`  in  1  transmitter idle.
- `tx_strb`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte to transmit; held stable from `tx_strb` onward.
- `rd_req`  out  1  read request to `hyper_xface`.
- `wr_req`  out  1  write request.
- `addr`  out  32  dword address.
- `wr_d`  out  32  write data.
- `wr_byte_en`  out  4  constant 4'hF.
- `rd_num_dwords`  out  6  constant 6'd1.
- `rd_d`  in  32  read data; valid when `rd_rdy`=1.
- `rd_rdy`  in  1  read data valid pulse.
- `busy`  in  1  controller busy.
- `err`  out  1  sticky; set on timeout or unknown command, cleared by reset or a ping.

## Operation
- Commands (first byte); multi-byte fields are MSB first:
  - 0x00 ping: no payload, reply 0x55, clears `err`.
  - 0x01 set addr: 4 payload bytes load `addr`; reply 0xAA.
  - 0x02 write: 4 payload bytes load `wr_d`, then a controller write at `addr`; reply 0xAA, then `addr`+=1.
  - 0x03 read: no payload, controller read at `addr`; reply is the 4 bytes of `rd_d` MSB first, then `addr`+=1.
  - Any other byte: reply 0xEE, set `err`.
- States: IDLE -> PAYLOAD (commands 0x01/0x02) -> ISSUE -> WAIT_DONE -> REPLY -> IDLE.
  - Ping, unknown and set-addr go straight to REPLY once their payload, if any, is complete.
- PAYLOAD:
  - A 2-bit byte counter counts 0..3; bytes shift into a 32-bit assembly register.
  - Each `rx_strb` reloads the RX timeout counter.
  - On expiry, go to IDLE silently, with no reply and no register change.
- ISSUE: hold `rd_req`/`wr_req` high until the first cycle `busy`=1 (accepted), deassert the next cycle, then enter WAIT_DONE.
- WAIT_DONE:
  - A write completes on the first cycle `busy`=0.
  - A read completes on the `rd_rdy` pulse; `rd_d` is captured that cycle.
- Bus timeout: one counter runs in ISSUE+WAIT_DONE.
  - At `BUS_TIMEOUT` the request drops, `err` sets, reply is the single byte 0xEE, and `addr` is unchanged.
- REPLY:
  - Pulse `tx_strb` only when `tx_ready`=1 and `tx_strb` was 0 the previous cycle.
  - Advance to the next byte after each pulse; return to IDLE after the last byte.
- `rx_strb` outside IDLE/PAYLOAD is dropped.
- `addr` increment is modulo 2^32: 0xFFFFFFFF -> 0x00000000.

## Timing
- Reset values: `rd_req`=0, `wr_req`=0, `tx_strb`=0, `tx_data`=0, `addr`=0, `wr_d`=0, `err`=0, state IDLE. `wr_byte_en`=4'hF and `rd_num_dwords`=1 at all times.
- Reset during any state: requests and `tx_strb` drop the next edge; no reply is sent.
- Reset and `rx_strb` in the same cycle: reset wins.
- Request rises 1 cycle after the final command/payload byte's `rx_strb`.
- `addr` updates on the cycle the last reply byte is strobed; the same holds for set-addr.
- `rd_rdy` and timeout expiry in the same cycle: `rd_rdy` wins (successful read).
- `busy` already high in ISSUE: the request is asserted, then dropped the next cycle once `busy`=1 is sampled.
- Minimum spacing between `tx_strb` pulses: 2 cycles.

## Test plan
- Ping: send 0x00 -> exactly one `tx_strb` with `tx_data`=0x55; `err`=0.
- Set addr: send 0x01,12,34,56,78 then 0x03; controller model returns 0xDEADBEEF -> `rd_req` seen with `addr`=0x12345678; TX bytes DE,AD,BE,EF; `addr`=0x12345679.
- Write with wrap: set addr 0xFFFFFFFF, send 0x02,CA,FE,F0,0D -> `wr_req` with `wr_d`=0xCAFEF00D at 0xFFFFFFFF; reply 0xAA; `addr`=0.
- Bus timeout: `busy` held 0 forever on a read -> `rd_req` drops after `BUS_TIMEOUT` cycles; reply 0xEE; `err`=1; `addr` unchanged. A following ping clears `err`.
- Partial payload: send 0x01,AA, then silence > `RX_TIMEOUT` -> no TX; `addr` unchanged; a following ping answers 0x55.
- Reset mid-read (in WAIT_DONE) -> `rd_req`=0, no TX, `addr`=0; `tx_ready` held low during REPLY delays strobes with no byte lost.
